gear_shift_controller: RTL and testbench

Driver-input stage directly upstream of the vehicle physics/RPM block. It debounces the shift-lever and low-gear-mode buttons, then runs the P/R/N/D selector state machine with brake and speed interlocks. Its registered outputs are the gear code, low-gear-mode flag and max-gear limit that the physics block consumes. It reads back `speed` from that block for the interlocks.

---
 rtl/gear_shift_controller_pkg.sv | 50 +++++
 rtl/gear_shift_controller_debouncer.sv | 63 ++++++
 rtl/gear_shift_controller.sv | 168 ++++++++++++++++
 tb/tb_gear_shift_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gear_shift_controller_pkg.sv
// rtl/gear_shift_controller_pkg.sv - gear codes, low-gear speed caps and selector helpers
package gear_shift_controller_pkg;

    localparam logic [3:0] GEAR_P = 4'd3;
    localparam logic [3:0] GEAR_R = 4'd6;
    localparam logic [3:0] GEAR_N = 4'd9;
    localparam logic [3:0] GEAR_D = 4'd12;

    localparam logic [7:0] CAP_LIM1 = 8'd35;
    localparam logic [7:0] CAP_LIM2 = 8'd65;
    localparam logic [7:0] CAP_LIM3 = 8'd95;

    localparam logic [2:0] LIM_MIN       = 3'd1;
    localparam logic [2:0] LIM_MAX       = 3'd6;
    localparam logic [2:0] LIM_LOW_ENTRY = 3'd3;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } hold_state_e;

    // Limits 4..6 carry no speed cap.
    function automatic logic speed_within_cap(input logic [2:0] lim, input logic [7:0] spd);
        case (lim)
            3'd1:    return spd <= CAP_LIM1;
            3'd2:    return spd <= CAP_LIM2;
            3'd3:    return spd <= CAP_LIM3;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] gear_toward_p(input logic [3:0] g);
        case (g)
            GEAR_R:  return GEAR_P;
            GEAR_N:  return GEAR_R;
            GEAR_D:  return GEAR_N;
            default: return g;
        endcase
    endfunction

    function automatic logic [3:0] gear_toward_d(input logic [3:0] g);
        case (g)
            GEAR_P:  return GEAR_R;
            GEAR_R:  return GEAR_N;
            GEAR_N:  return GEAR_D;
            default: return g;
        endcase
    endfunction

endpackage

// File: rtl/gear_shift_controller_debouncer.sv
// rtl/gear_shift_controller_debouncer.sv - synchronizing tick-based button debouncer with rise pulse
module button_debouncer #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_1ms,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_MS);

    logic          sync1_q, sync2_q;
    logic          cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick_1ms) begin
            if (sync2_q == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cand_d = sync2_q;
                cnt_d  = '0;
            end
        end
        if (cnt_d == CNT_MAX) begin
            level_d = cand_d;
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cand_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/gear_shift_controller.sv
// rtl/gear_shift_controller.sv - P/R/N/D selector with interlocks, lever lockout and low-gear mode
module gear_shift_controller
    import gear_shift_controller_pkg::*;
#(
    parameter int DEBOUNCE_MS   = 20,
    parameter int SHIFT_HOLD_MS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       engine_on,
    input  logic       btn_lever_fwd,
    input  logic       btn_lever_back,
    input  logic       btn_low_mode,
    input  logic       btn_gear_plus,
    input  logic       btn_gear_minus,
    input  logic       is_brake_normal,
    input  logic       is_brake_hard,
    input  logic [7:0] speed,
    output logic [3:0] current_gear,
    output logic       is_low_gear_mode,
    output logic [2:0] max_gear_limit,
    output logic       shift_ack,
    output logic       shift_reject,
    output logic       hold_active
);

    localparam int HW = $clog2(SHIFT_HOLD_MS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(SHIFT_HOLD_MS);

    logic [4:0] raw_vec;
    logic [4:0] rise_vec;
    logic [4:0] unused_levels;

    assign raw_vec = {btn_gear_minus, btn_gear_plus, btn_low_mode, btn_lever_back, btn_lever_fwd};

    for (genvar i = 0; i < 5; i++) begin : g_deb
        button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb (
            .clk      (clk),
            .rst      (rst),
            .tick_1ms (tick_1ms),
            .raw      (raw_vec[i]),
            .level    (unused_levels[i]),
            .rise     (rise_vec[i])
        );
    end

    hold_state_e   state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]    gear_q, gear_d;
    logic          low_q, low_d;
    logic [2:0]    lim_q, lim_d;
    logic          ack_q, ack_d;
    logic          rej_q, rej_d;
    logic          hold_q;
    logic [3:0]    target;
    logic          lever_ok;
    logic [2:0]    lim_dec;

    logic req_fwd, req_back, req_low, req_plus, req_minus;
    assign {req_minus, req_plus, req_low, req_back, req_fwd} = rise_vec;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gear_d     = gear_q;
        low_d      = low_q;
        lim_d      = lim_q;
        ack_d      = 1'b0;
        rej_d      = 1'b0;
        target     = gear_q;
        lever_ok   = 1'b0;
        lim_dec    = lim_q - 1'b1;

        if (state_q == S_HOLD && tick_1ms) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
            if (hold_cnt_q == HW'(1)) begin
                state_d = S_IDLE;
            end
        end

        // Lever requests win; any low-mode request in the same cycle is dropped silently.
        if (req_fwd || req_back) begin
            if (req_fwd && req_back) begin
                rej_d = 1'b1;
            end else begin
                target   = req_fwd ? gear_toward_p(gear_q) : gear_toward_d(gear_q);
                lever_ok = engine_on && (state_q == S_IDLE) && (target != gear_q);
                if (gear_q == GEAR_P) begin
                    lever_ok = lever_ok && (is_brake_normal || is_brake_hard) && (speed == 8'd0);
                end
                if (target == GEAR_P) begin
                    lever_ok = lever_ok && (speed == 8'd0);
                end
                if (gear_q == GEAR_N && target == GEAR_R) begin
                    lever_ok = lever_ok && (speed == 8'd0);
                end
                if (lever_ok) begin
                    gear_d     = target;
                    ack_d      = 1'b1;
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                    if (target != GEAR_D) begin
                        low_d = 1'b0;
                    end
                end else begin
                    rej_d = 1'b1;
                end
            end
        end else if (req_low) begin
            if (gear_q == GEAR_D) begin
                ack_d = 1'b1;
                low_d = ~low_q;
                if (!low_q) begin
                    lim_d = LIM_LOW_ENTRY;
                end
            end else begin
                rej_d = 1'b1;
            end
        end else if (req_plus && req_minus) begin
            rej_d = 1'b1;
        end else if (req_plus) begin
            if (low_q && lim_q < LIM_MAX) begin
                lim_d = lim_q + 1'b1;
                ack_d = 1'b1;
            end else begin
                rej_d = 1'b1;
            end
        end else if (req_minus) begin
            if (low_q && lim_q > LIM_MIN && speed_within_cap(lim_dec, speed)) begin
                lim_d = lim_dec;
                ack_d = 1'b1;
            end else begin
                rej_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            gear_q     <= GEAR_P;
            low_q      <= 1'b0;
            lim_q      <= LIM_LOW_ENTRY;
            ack_q      <= 1'b0;
            rej_q      <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gear_q     <= gear_d;
            low_q      <= low_d;
            lim_q      <= lim_d;
            ack_q      <= ack_d;
            rej_q      <= rej_d;
            hold_q     <= (state_d == S_HOLD);
        end
    end

    assign current_gear     = gear_q;
    assign is_low_gear_mode = low_q;
    assign max_gear_limit   = lim_q;
    assign shift_ack        = ack_q;
    assign shift_reject     = rej_q;
    assign hold_active      = hold_q;

endmodule

// File: tb/tb_gear_shift_controller.sv
// tb/tb_gear_shift_controller.sv - directed self-checking bench for gear_shift_controller
module tb_gear_shift_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] div = 2'd0;
    logic       engine_on = 1'b1;
    logic       fwd = 1'b0, back = 1'b0, low = 1'b0, plus = 1'b0, minus = 1'b0;
    logic       brake_n = 1'b0, brake_h = 1'b0;
    logic [7:0] speed = 8'd0;
    logic [3:0] gear;
    logic       low_mode;
    logic [2:0] lim;
    logic       ack, rej, hold;

    int checks = 0;
    int errors = 0;
    int tick_count = 0;

    localparam logic [4:0] M_FWD = 5'b00001, M_BACK = 5'b00010, M_LOW = 5'b00100;
    localparam logic [4:0] M_PLUS = 5'b01000, M_MINUS = 5'b10000;

    gear_shift_controller dut (
        .clk              (clk),
        .rst              (rst),
        .tick_1ms         (tick),
        .engine_on        (engine_on),
        .btn_lever_fwd    (fwd),
        .btn_lever_back   (back),
        .btn_low_mode     (low),
        .btn_gear_plus    (plus),
        .btn_gear_minus   (minus),
        .is_brake_normal  (brake_n),
        .is_brake_hard    (brake_h),
        .speed            (speed),
        .current_gear     (gear),
        .is_low_gear_mode (low_mode),
        .max_gear_limit   (lim),
        .shift_ack        (ack),
        .shift_reject     (rej),
        .hold_active      (hold)
    );

    always #5 clk = ~clk;

    // 1 ms tick every 4 clocks keeps the 200 ms lockout short in simulation.
    always @(posedge clk) begin
        div  <= div + 2'd1;
        tick <= (div == 2'd3);
        if (tick) tick_count <= tick_count + 1;
    end

    // code: 0 none, 1 ack, 2 reject, 3 ack and reject together
    task automatic press(input logic [4:0] mask, output int code, output int pulses, output int at_tick);
        code = 0; pulses = 0; at_tick = 0;
        {minus, plus, low, back, fwd} = mask;
        for (int i = 0; i < 280; i++) begin
            @(posedge clk); #1;
            if (ack || rej) begin
                pulses++;
                if (code == 0) begin
                    code = (ack && rej) ? 3 : (ack ? 1 : 2);
                    at_tick = tick_count;
                end
            end
        end
        {minus, plus, low, back, fwd} = 5'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (ack || rej) pulses++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1200 && hold; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (hold !== 1'b0) begin errors++; $display("FAIL wait_idle: hold_active=%b required 0", hold); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (gear !== 4'd3) begin errors++; $display("FAIL reset_gear: got %0d want 3", gear); end
        if (low_mode !== 1'b0) begin errors++; $display("FAIL reset_low: got %b want 0", low_mode); end
        if (lim !== 3'd3) begin errors++; $display("FAIL reset_lim: got %0d want 3", lim); end
        if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        if (rej !== 1'b0) begin errors++; $display("FAIL reset_rej: got %b want 0", rej); end
        if (hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", hold); end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_park_interlock();
        int c, p, t;
        brake_n = 1'b0; speed = 8'd0;
        press(M_BACK, c, p, t);
        checks += 2;
        if (c !== 2) begin errors++; $display("FAIL park_nobrake_code: got %0d want 2", c); end
        if (gear !== 4'd3) begin errors++; $display("FAIL park_nobrake_gear: got %0d want 3", gear); end
        brake_n = 1'b1;
        press(M_BACK, c, p, t);
        checks += 3;
        if (c !== 1) begin errors++; $display("FAIL park_brake_code: got %0d want 1", c); end
        if (gear !== 4'd6) begin errors++; $display("FAIL park_brake_gear: got %0d want 6", gear); end
        if (hold !== 1'b1) begin errors++; $display("FAIL park_hold_on: got %b want 1", hold); end
        wait_idle();
        checks++;
        if (tick_count - t !== 200) begin
            errors++; $display("FAIL hold_length: got %0d ticks want 200", tick_count - t);
        end
    endtask

    task automatic test_speed_interlock();
        int c, p, t;
        press(M_BACK, c, p, t);
        wait_idle();
        press(M_BACK, c, p, t);
        checks++;
        if (gear !== 4'd12) begin errors++; $display("FAIL reach_d: got %0d want 12", gear); end
        wait_idle();
        speed = 8'd40;
        press(M_FWD, c, p, t);
        checks += 2;
        if (c !== 1) begin errors++; $display("FAIL d_to_n_code: got %0d want 1", c); end
        if (gear !== 4'd9) begin errors++; $display("FAIL d_to_n_gear: got %0d want 9", gear); end
        wait_idle();
        press(M_FWD, c, p, t);
        checks += 2;
        if (c !== 2) begin errors++; $display("FAIL n_to_r_moving_code: got %0d want 2", c); end
        if (gear !== 4'd9) begin errors++; $display("FAIL n_to_r_moving_gear: got %0d want 9", gear); end
        speed = 8'd0;
        press(M_FWD, c, p, t);
        checks += 2;
        if (c !== 1) begin errors++; $display("FAIL n_to_r_stopped_code: got %0d want 1", c); end
        if (gear !== 4'd6) begin errors++; $display("FAIL n_to_r_stopped_gear: got %0d want 6", gear); end
    endtask

    task automatic test_hold_lockout();
        int c, p, t;
        wait_idle();
        press(M_BACK, c, p, t);
        checks++;
        if (c !== 1) begin errors++; $display("FAIL lock_first_code: got %0d want 1", c); end
        press(M_BACK, c, p, t);
        checks += 2;
        if (c !== 2) begin errors++; $display("FAIL lock_second_code: got %0d want 2", c); end
        if (gear !== 4'd9) begin errors++; $display("FAIL lock_second_gear: got %0d want 9", gear); end
        wait_idle();
        press(M_BACK, c, p, t);
        checks += 2;
        if (c !== 1) begin errors++; $display("FAIL lock_third_code: got %0d want 1", c); end
        if (gear !== 4'd12) begin errors++; $display("FAIL lock_third_gear: got %0d want 12", gear); end
    endtask

    task automatic test_low_mode();
        int c, p, t;
        speed = 8'd0;
        press(M_LOW, c, p, t);
        checks += 3;
        if (c !== 1) begin errors++; $display("FAIL low_enter_code: got %0d want 1", c); end
        if (low_mode !== 1'b1) begin errors++; $display("FAIL low_enter_mode: got %b want 1", low_mode); end
        if (lim !== 3'd3) begin errors++; $display("FAIL low_enter_lim: got %0d want 3", lim); end
        speed = 8'd70;
        press(M_MINUS, c, p, t);
        checks += 2;
        if (c !== 2) begin errors++; $display("FAIL minus_70_code: got %0d want 2", c); end
        if (lim !== 3'd3) begin errors++; $display("FAIL minus_70_lim: got %0d want 3", lim); end
        speed = 8'd60;
        press(M_MINUS, c, p, t);
        checks += 2;
        if (c !== 1) begin errors++; $display("FAIL minus_60_code: got %0d want 1", c); end
        if (lim !== 3'd2) begin errors++; $display("FAIL minus_60_lim: got %0d want 2", lim); end
        for (int i = 0; i < 5; i++) begin
            press(M_PLUS, c, p, t);
            checks++;
            if (c !== ((i < 4) ? 1 : 2)) begin
                errors++; $display("FAIL plus_%0d_code: got %0d want %0d", i, c, (i < 4) ? 1 : 2);
            end
        end
        checks++;
        if (lim !== 3'd6) begin errors++; $display("FAIL plus_sat_lim: got %0d want 6", lim); end
        wait_idle();
        press(M_FWD, c, p, t);
        checks += 3;
        if (gear !== 4'd9) begin errors++; $display("FAIL leave_d_gear: got %0d want 9", gear); end
        if (low_mode !== 1'b0) begin errors++; $display("FAIL leave_d_mode: got %b want 0", low_mode); end
        if (lim !== 3'd6) begin errors++; $display("FAIL leave_d_lim: got %0d want 6", lim); end
    endtask

    task automatic test_glitch();
        int p;
        p = 0;
        wait_idle();
        back = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (ack || rej) p++; end
        back = 1'b0;
        repeat (160) begin @(posedge clk); #1; if (ack || rej) p++; end
        checks += 2;
        if (p !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", p); end
        if (gear !== 4'd9) begin errors++; $display("FAIL glitch_gear: got %0d want 9", gear); end
    endtask

    task automatic test_simultaneous();
        int c, p, t;
        press(M_FWD | M_BACK, c, p, t);
        checks += 3;
        if (c !== 2) begin errors++; $display("FAIL both_code: got %0d want 2", c); end
        if (p !== 1) begin errors++; $display("FAIL both_pulses: got %0d want 1", p); end
        if (gear !== 4'd9) begin errors++; $display("FAIL both_gear: got %0d want 9", gear); end
        engine_on = 1'b0;
        press(M_BACK, c, p, t);
        checks += 2;
        if (c !== 2) begin errors++; $display("FAIL engine_off_code: got %0d want 2", c); end
        if (gear !== 4'd9) begin errors++; $display("FAIL engine_off_gear: got %0d want 9", gear); end
        engine_on = 1'b1;
    endtask

    task automatic test_reset_in_hold();
        int c, p, t;
        press(M_BACK, c, p, t);
        checks += 2;
        if (gear !== 4'd12) begin errors++; $display("FAIL pre_reset_gear: got %0d want 12", gear); end
        if (hold !== 1'b1) begin errors++; $display("FAIL pre_reset_hold: got %b want 1", hold); end
        rst = 1'b0;
        #1;
        checks += 4;
        if (gear !== 4'd3) begin errors++; $display("FAIL mid_reset_gear: got %0d want 3", gear); end
        if (hold !== 1'b0) begin errors++; $display("FAIL mid_reset_hold: got %b want 0", hold); end
        if (lim !== 3'd3) begin errors++; $display("FAIL mid_reset_lim: got %0d want 3", lim); end
        if (ack !== 1'b0 || rej !== 1'b0) begin
            errors++; $display("FAIL mid_reset_pulses: ack=%b rej=%b want 0 0", ack, rej);
        end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        p = 0;
        repeat (200) begin @(posedge clk); #1; if (ack || rej || hold) p++; end
        checks += 2;
        if (p !== 0) begin errors++; $display("FAIL post_reset_activity: got %0d want 0", p); end
        if (gear !== 4'd3) begin errors++; $display("FAIL post_reset_gear: got %0d want 3", gear); end
    endtask

    initial begin
        test_reset();
        test_park_interlock();
        test_speed_interlock();
        test_hold_lockout();
        test_low_mode();
        test_glitch();
        test_simultaneous();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
